// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register completer.
// Holds the FSM encoding, the latched request payload and the address-error rule.
package apb_slave_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WIDX_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

  // Request captured on the setup edge and replayed through the access phase
  typedef struct packed {
    logic              write;
    logic              err;
    logic [WIDX_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Misaligned, beyond the bank, or a write to the read-only ID register
  function automatic logic addr_err(input logic [9:0]  addr,
                                    input logic        write,
                                    input int unsigned num_regs);
    logic [WIDX_W-1:0] idx;
    idx = addr[9:2];
    return (addr[1:0] != 2'b00) || (32'(idx) >= num_regs) || (write && (idx == '0));
  endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB completer-side bus bundle.
// The initiator drives select/enable/address/data; the completer returns data, ready and error.
interface apb_slave_regs_if;

  logic                              PSEL;
  logic                              PENABLE;
  logic                              PWRITE;
  logic [apb_slave_pkg::ADDR_W-1:0]  PADDR;
  logic [apb_slave_pkg::DATA_W-1:0]  PWDATA;
  logic [apb_slave_pkg::DATA_W-1:0]  PRDATA;
  logic                              PREADY;
  logic                              PSLVERR;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );

endinterface

// File: rtl/apb_reg_bank.sv
// Register storage behind the APB completer: writable regs 1..N-1, constant ID at index 0.
// Decodes committed writes into per-register enables and one-cycle write strobes.
module apb_reg_bank
  import apb_slave_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 8,
  parameter int unsigned       IDX_W    = 3,
  parameter logic [DATA_W-1:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [IDX_W-1:0]           i_widx,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [IDX_W-1:0]           i_ridx,
  output logic [DATA_W-1:0]          o_rdata_c,
  output logic [NUM_REGS*DATA_W-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]        o_wr_pulse
);

  logic [NUM_REGS-1:1][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_wr_pulse;
  logic [NUM_REGS-1:0]             w_we;

  // Index 0 never decodes, so the ID register cannot be overwritten here either
  always_comb begin
    w_we = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      w_we[i] = i_we && (i_widx == IDX_W'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs     <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_we;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= i_wdata;
        end
      end
    end
  end

  // Out-of-range indices fall through to ID; the caller masks them to zero on error
  always_comb begin
    o_rdata_c = ID_VALUE;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (i_ridx == IDX_W'(i)) begin
        o_rdata_c = r_regs[i];
      end
    end
  end

  assign o_reg_q    = {r_regs, ID_VALUE};
  assign o_wr_pulse = r_wr_pulse;

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer fronting a bank of 32-bit control/status registers.
// Runs the setup / wait / ready handshake and hands committed writes to the bank.
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 8,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  apb_slave_regs_if.slave            bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int unsigned      IDX_W   = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

  state_e              r_state;
  state_e              w_state_nxt;
  req_t                r_req;
  req_t                w_in_req;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pready;
  logic                r_pslverr;
  logic [DATA_W-1:0]   r_prdata;

  logic                w_latch;
  logic                w_enter_ready;
  logic                w_leave;
  logic                w_commit;
  logic [WIDX_W-1:0]   w_rd_idx;
  logic                w_rd_err;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  always_comb begin
    w_in_req.write = bus.PWRITE;
    w_in_req.err   = addr_err(bus.PADDR[9:0], bus.PWRITE, NUM_REGS);
    w_in_req.idx   = bus.PADDR[9:2];
    w_in_req.wdata = bus.PWDATA;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping PSEL outside IDLE aborts; PSEL&PENABLE in READY completes
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.PSEL) begin
          w_state_nxt = (WAIT_STATES == 0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!bus.PSEL) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        if (!bus.PSEL || bus.PENABLE) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_latch       = 1'b0;
    w_enter_ready = 1'b0;
    w_leave       = 1'b0;
    w_commit      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_latch       = bus.PSEL;
        w_enter_ready = bus.PSEL && (WAIT_STATES == 0);
      end
      WAIT: begin
        w_leave       = !bus.PSEL;
        w_enter_ready = bus.PSEL && (r_cnt == CNT_W'(1));
      end
      READY: begin
        w_leave  = !bus.PSEL || bus.PENABLE;
        w_commit = bus.PSEL && bus.PENABLE && r_req.write && !r_req.err;
      end
      default: ;
    endcase
  end

  // On a zero-wait setup edge the read must come from the bus, not the stale latch
  assign w_rd_idx = w_latch ? w_in_req.idx : r_req.idx;
  assign w_rd_err = w_latch ? w_in_req.err : r_req.err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_req     <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      if (w_latch) begin
        r_req <= w_in_req;
        r_cnt <= WS_INIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // PRDATA only moves when entering READY, so it holds between transfers
      if (w_enter_ready) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_rd_err;
        r_prdata  <= w_rd_err ? '0 : w_rdata;
      end else if (w_leave) begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
      end
    end
  end

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .i_clk      (PCLK),
    .i_rst_n    (PRESETn),
    .i_we       (w_commit),
    .i_widx     (IDX_W'(r_req.idx)),
    .i_wdata    (r_req.wdata),
    .i_ridx     (IDX_W'(w_rd_idx)),
    .o_rdata_c  (w_rdata),
    .o_reg_q    (reg_q),
    .o_wr_pulse (wr_pulse)
  );

  assign bus.PREADY  = r_pready;
  assign bus.PSLVERR = r_pslverr;
  assign bus.PRDATA  = r_prdata;

  // High address bits alias; index bits above IDX_W only matter to the range check
  assign w_unused = ^{bus.PADDR[ADDR_W-1:10], r_req.idx, w_rd_idx};

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench: three completers (0, 3 and 2 wait states) driven by directed and
// random APB transfers, compared against a word-array model of the register file.
module tb_apb_slave_regs;

  localparam int unsigned NREG = 8;
  localparam int unsigned QW   = NREG * 32;
  localparam int unsigned NDEV = 3;
  localparam int unsigned WS [NDEV] = '{0, 3, 2};
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst_n;

  logic        psel    [NDEV];
  logic        penable [NDEV];
  logic        pwrite  [NDEV];
  logic [31:0] paddr   [NDEV];
  logic [31:0] pwdata  [NDEV];
  logic [31:0] prdata  [NDEV];
  logic        pready  [NDEV];
  logic        pslverr [NDEV];
  logic [QW-1:0]   regq [NDEV];
  logic [NREG-1:0] wrp  [NDEV];

  logic [31:0] model [NDEV][NREG];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDEV; g++) begin : g_dut
    apb_slave_regs_if bus ();
    assign bus.PSEL    = psel[g];
    assign bus.PENABLE = penable[g];
    assign bus.PWRITE  = pwrite[g];
    assign bus.PADDR   = paddr[g];
    assign bus.PWDATA  = pwdata[g];
    assign prdata[g]   = bus.PRDATA;
    assign pready[g]   = bus.PREADY;
    assign pslverr[g]  = bus.PSLVERR;

    apb_slave_regs #(
      .NUM_REGS    (NREG),
      .WAIT_STATES (WS[g]),
      .ID_VALUE    (ID)
    ) u_dut (
      .PCLK     (clk),
      .PRESETn  (rst_n),
      .bus      (bus),
      .reg_q    (regq[g]),
      .wr_pulse (wrp[g])
    );
  end

  task automatic chk(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [QW-1:0] exp_q(input int d);
    logic [QW-1:0] v;
    v = '0;
    v[31:0] = ID;
    for (int i = 1; i < int'(NREG); i++) v[32*i +: 32] = model[d][i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int d = 0; d < int'(NDEV); d++)
      for (int i = 0; i < int'(NREG); i++) model[d][i] = '0;
  endtask

  // One full transfer: setup, wait for PREADY (bounded), completion, then the expectations
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit mstyle);
    int              idx;
    bit              err;
    int              waits;
    logic [31:0]     exp_rd;
    logic [NREG-1:0] exp_pulse;
    idx = int'((addr >> 2) % 256);
    err = (addr % 4 != 0) || (idx >= int'(NREG)) || (wr && idx == 0);
    exp_rd = err ? 32'h0 : (idx == 0 ? ID : model[d][idx]);

    psel[d] = 1'b1; penable[d] = mstyle; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    tick();
    chk($sformatf("d%0d_pulse_quiet", d), QW'(wrp[d]), '0);
    penable[d] = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      tick();
      waits++;
    end
    chk($sformatf("d%0d_wait_cycles", d), QW'(waits), QW'(WS[d]));
    chk($sformatf("d%0d_pslverr a=%0h", d, addr), QW'(pslverr[d]), QW'(err));
    if (!wr) chk($sformatf("d%0d_prdata a=%0h", d, addr), QW'(prdata[d]), QW'(exp_rd));
    tick();
    psel[d] = 1'b0; penable[d] = 1'b0;

    exp_pulse = '0;
    if (wr && !err) begin
      model[d][idx] = wd;
      exp_pulse[idx] = 1'b1;
    end
    chk($sformatf("d%0d_ready_drop", d), QW'({pready[d], pslverr[d]}), '0);
    chk($sformatf("d%0d_wr_pulse", d), QW'(wrp[d]), QW'(exp_pulse));
    chk($sformatf("d%0d_reg_q", d), regq[d], exp_q(d));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    int          word;

    rst_n = 1'b0;
    for (int d = 0; d < int'(NDEV); d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    clear_model();
    repeat (3) tick();
    for (int d = 0; d < int'(NDEV); d++) begin
      chk($sformatf("d%0d_rst_flags", d), QW'({pready[d], pslverr[d]}), '0);
      chk($sformatf("d%0d_rst_prdata", d), QW'(prdata[d]), '0);
      chk($sformatf("d%0d_rst_reg_q", d), regq[d], exp_q(d));
      chk($sformatf("d%0d_rst_pulse", d), QW'(wrp[d]), '0);
    end
    rst_n = 1'b1;
    tick();

    // Zero-wait write then readback, and the ID register on the 3-wait completer
    xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 32'h4, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'hFFFF_F004, 32'h0, 1'b0);

    // Error cases on every completer
    for (int d = 0; d < int'(NDEV); d++) begin
      xfer(d, 1'b1, 32'h0,  32'h1111_2222, 1'b0);
      xfer(d, 1'b1, 32'h20, 32'h3333_4444, 1'b0);
      xfer(d, 1'b0, 32'h6,  32'h0, 1'b0);
    end

    // Master-style back-to-back writes and readbacks
    for (int d = 0; d < int'(NDEV); d++) begin
      for (int i = 1; i <= 3; i++) xfer(d, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 16 + d), 1'b1);
      for (int i = 1; i <= 3; i++) xfer(d, 1'b0, 32'(i * 4), 32'h0, 1'b1);
    end

    // Abort a write to reg 2 on the 2-wait completer while it is still waiting
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h8; pwdata[2] = 32'h2222_2222;
    tick();
    penable[2] = 1'b1;
    tick();
    chk("abort_wait_pready", QW'(pready[2]), '0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    tick();
    chk("abort_pready", QW'(pready[2]), '0);
    chk("abort_pulse0", QW'(wrp[2]), '0);
    tick();
    chk("abort_pulse1", QW'(wrp[2]), '0);
    chk("abort_reg_q", regq[2], exp_q(2));
    xfer(2, 1'b0, 32'h8, 32'h0, 1'b0);

    // Random traffic, including aliasing, out-of-range and misaligned addresses
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < int'(NDEV); d++) begin
        word = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
        a = ($urandom() & 32'hFFFF_FC00) | 32'(word * 4);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end

    // Reset in the middle of a write on the 3-wait completer
    xfer(1, 1'b1, 32'h4, 32'h5A5A_1234, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'h0, 1'b0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'h7777_8888;
    tick();
    penable[1] = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    clear_model();
    r = prdata[1];
    chk("rst_mid_prdata", QW'(r), '0);
    chk("rst_mid_flags", QW'({pready[1], pslverr[1]}), '0);
    chk("rst_mid_reg_q", regq[1], exp_q(1));
    psel[1] = 1'b0; penable[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after_pulse0", QW'(wrp[1]), '0);
    tick();
    chk("rst_after_pulse1", QW'(wrp[1]), '0);
    chk("rst_after_reg_q", regq[1], exp_q(1));
    xfer(1, 1'b0, 32'h8, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
